// File: rtl/bmp_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the BMP writer pixel port between two sources.
// Optional stall-timeout abort is compiled in when ARB_TIMEOUT_EN is defined.

module bmp_frame_arbiter #(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        s0_valid,
  input  logic [7:0]  s0_r,
  input  logic [7:0]  s0_g,
  input  logic [7:0]  s0_b,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [7:0]  s1_r,
  input  logic [7:0]  s1_g,
  input  logic [7:0]  s1_b,
  output logic        s1_ready,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [7:0]  wr_r,
  output logic [7:0]  wr_g,
  output logic [7:0]  wr_b,
  output logic [15:0] wr_row,
  output logic [15:0] wr_col,
  output logic        wr_last,
  output logic        wr_src,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_grant;
  logic        r_prio;
  logic [15:0] r_row;
  logic [15:0] r_col;
  logic        r_wr_en;
  logic        r_wr_last;
  logic [7:0]  r_wr_r;
  logic [7:0]  r_wr_g;
  logic [7:0]  r_wr_b;
  logic [15:0] r_wr_row;
  logic [15:0] r_wr_col;

  logic        w_stream;
  logic        w_src_valid;
  logic        w_xfer;
  logic        w_last_px;
  logic        w_timeout;
  logic        w_any_valid;

  assign w_stream    = (r_state == S_STREAM);
  assign w_any_valid = s0_valid || s1_valid;
  assign w_src_valid = r_grant ? s1_valid : s0_valid;
  assign w_xfer      = w_stream && w_src_valid && wr_ready;
  assign w_last_px   = (r_col == LAST_COL) && (r_row == LAST_ROW);

  assign s0_ready = w_stream && !r_grant && wr_ready;
  assign s1_ready = w_stream &&  r_grant && wr_ready;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_stall;
  logic        r_abort;

  // Only cycles where the writer could accept but the granted source has nothing count as stall.
  assign w_timeout = w_stream && !w_xfer && (r_stall == 16'(TIMEOUT));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      if (!w_stream || w_xfer)
        r_stall <= '0;
      else if (wr_ready)
        r_stall <= r_stall + 16'd1;
      if (w_timeout)
        r_abort <= 1'b1;
      else if (r_state == S_DONE)
        r_abort <= 1'b0;
    end
  end

  assign frame_done  = (r_state == S_DONE) && !r_abort;
  assign frame_abort = (r_state == S_DONE) &&  r_abort;
`else
  assign w_timeout   = 1'b0;
  assign frame_done  = (r_state == S_DONE);
  assign frame_abort = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_any_valid) w_next_state = S_STREAM;
      S_STREAM: if ((w_xfer && w_last_px) || w_timeout) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant   <= 1'b0;
      r_prio    <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_last <= 1'b0;
      r_wr_r    <= '0;
      r_wr_g    <= '0;
      r_wr_b    <= '0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else begin
      r_wr_en   <= w_xfer;
      r_wr_last <= w_xfer && w_last_px;
      if (w_xfer) begin
        r_wr_r   <= r_grant ? s1_r : s0_r;
        r_wr_g   <= r_grant ? s1_g : s0_g;
        r_wr_b   <= r_grant ? s1_b : s0_b;
        r_wr_row <= r_row;
        r_wr_col <= r_col;
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
      // With both requesting, prio picks; a lone requester always wins.
      if (r_state == S_IDLE && w_any_valid)
        r_grant <= (s0_valid && s1_valid) ? r_prio : s1_valid;
      if (r_state == S_DONE) begin
        r_prio <= ~r_grant;
        r_row  <= '0;
        r_col  <= '0;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_r    = r_wr_r;
  assign wr_g    = r_wr_g;
  assign wr_b    = r_wr_b;
  assign wr_row  = r_wr_row;
  assign wr_col  = r_wr_col;
  assign wr_last = r_wr_last;
  assign wr_src  = r_grant;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_bmp_frame_arbiter.sv
// Self-checking bench for bmp_frame_arbiter: vector table, directed corner cases and a
// randomized run against a pixel-index reference model.

module tb_bmp_frame_arbiter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int TO = 5;

  logic        HCLK;
  logic        HRESETn;
  logic        s0_valid, s1_valid;
  logic [7:0]  s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
  logic        s0_ready, s1_ready;
  logic        wr_ready;
  logic        wr_en;
  logic [7:0]  wr_r, wr_g, wr_b;
  logic [15:0] wr_row, wr_col;
  logic        wr_last, wr_src, busy, frame_done, frame_abort;

  bmp_frame_arbiter #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .s0_valid(s0_valid), .s0_r(s0_r), .s0_g(s0_g), .s0_b(s0_b), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_r(s1_r), .s1_g(s1_g), .s1_b(s1_b), .s1_ready(s1_ready),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .wr_row(wr_row), .wr_col(wr_col), .wr_last(wr_last), .wr_src(wr_src),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    logic        v0, v1, rdy;
    logic [7:0]  pix;
    logic        eRdy0, eEn;
    logic [15:0] eRow, eCol;
    logic        eLast, eDone, eBusy;
  } vec_t;

  vec_t tbl[11];

  // Reference model state: frame progress is a flat pixel index, coordinates derived by division.
  bit   mBusy, mDone, mAbort, mSrc, mPrio;
  int   mN, mStall;
  logic eEn, eLast;
  logic [7:0] eR, eG, eB;
  int   eRow, eCol;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset;
    mBusy = 0; mDone = 0; mAbort = 0; mSrc = 0; mPrio = 0; mN = 0; mStall = 0;
    eEn = 0; eLast = 0; eR = 0; eG = 0; eB = 0; eRow = 0; eCol = 0;
  endtask

  task automatic randPix;
    s0_r = 8'($urandom); s0_g = 8'($urandom); s0_b = 8'($urandom);
    s1_r = 8'($urandom); s1_g = 8'($urandom); s1_b = 8'($urandom);
  endtask

  task automatic doReset;
    HRESETn = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; wr_ready = 1'b1;
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    modelReset();
  endtask

  // Called at a negedge with inputs already driven; compares, advances the model, moves one cycle.
  task automatic modelCycle;
    bit streaming, srcValid, xfer, r0, r1, toOn;
`ifdef ARB_TIMEOUT_EN
    toOn = 1'b1;
`else
    toOn = 1'b0;
`endif
    #1;
    streaming = mBusy && !mDone;
    r0 = streaming && !mSrc && wr_ready;
    r1 = streaming &&  mSrc && wr_ready;
    checkOutput("s0_ready", s0_ready, r0);
    checkOutput("s1_ready", s1_ready, r1);
    checkOutput("busy", busy, mBusy);
    checkOutput("frame_done", frame_done, mDone && !mAbort);
    checkOutput("frame_abort", frame_abort, mDone && mAbort);
    checkOutput("wr_en", wr_en, eEn);
    checkOutput("wr_last", wr_last, eLast);
    if (mBusy) checkOutput("wr_src", wr_src, mSrc);
    if (eEn) begin
      checkOutput("wr_row", wr_row, eRow);
      checkOutput("wr_col", wr_col, eCol);
      checkOutput("wr_rgb", {wr_r, wr_g, wr_b}, {eR, eG, eB});
    end
    srcValid = mSrc ? s1_valid : s0_valid;
    xfer = streaming && srcValid && wr_ready;
    eEn = xfer;
    eLast = 1'b0;
    if (xfer) begin
      eR = mSrc ? s1_r : s0_r;
      eG = mSrc ? s1_g : s0_g;
      eB = mSrc ? s1_b : s0_b;
      eRow = mN / W;
      eCol = mN % W;
      eLast = (mN == W * H - 1);
      mN++;
    end
    if (mDone) begin
      mBusy = 0; mDone = 0; mAbort = 0; mPrio = !mSrc; mN = 0; mStall = 0;
    end else if (streaming) begin
      if (xfer) begin
        mStall = 0;
        if (mN == W * H) mDone = 1;
      end else if (toOn && mStall == TO) begin
        mDone = 1; mAbort = 1;
      end else if (toOn && wr_ready && !srcValid) begin
        mStall++;
      end
    end else if (s0_valid || s1_valid) begin
      mBusy = 1;
      mSrc = (s0_valid && s1_valid) ? mPrio : s1_valid;
      mN = 0; mStall = 0;
    end
    @(posedge HCLK); @(negedge HCLK);
  endtask

  task automatic applyStimulus(input int k);
    s0_valid = tbl[k].v0; s1_valid = tbl[k].v1; wr_ready = tbl[k].rdy;
    s0_r = tbl[k].pix; s0_g = ~tbl[k].pix; s0_b = tbl[k].pix ^ 8'h5A;
    s1_r = 8'($urandom); s1_g = 8'($urandom); s1_b = 8'($urandom);
  endtask

  initial begin
    int enIdx[$];
    int srcAtDone[$];
    int nStream, nEn, nDone, lastXfer, abortAt;
    bit seenFirst;

    // v0 v1 rdy pix | eRdy0 eEn eRow eCol eLast eDone eBusy
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 16'd0, 16'd2, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 16'd0, 16'd3, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h16, 1'b1, 1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 1'b1, 16'd1, 16'd3, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h19, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};

    HRESETn = 1'b0; s0_valid = 0; s1_valid = 0; wr_ready = 1'b1;
    s0_r = 0; s0_g = 0; s0_b = 0; s1_r = 0; s1_g = 0; s1_b = 0;
    modelReset();
    @(negedge HCLK); @(negedge HCLK);
    checkOutput("in_reset_busy", busy, 0);
    checkOutput("in_reset_wr_en", wr_en, 0);
    HRESETn = 1'b1;
    @(negedge HCLK); @(negedge HCLK);
    #1;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rgb", {wr_r, wr_g, wr_b}, 0);
    checkOutput("rst_row_col", {wr_row, wr_col}, 0);
    checkOutput("rst_last_src", {wr_last, wr_src}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_abort", {frame_done, frame_abort}, 0);
    checkOutput("rst_ready", {s0_ready, s1_ready}, 0);
    @(negedge HCLK);

    for (int k = 0; k < 11; k++) begin
      applyStimulus(k);
      #1;
      checkOutput($sformatf("tbl%0d_s0_ready", k), s0_ready, tbl[k].eRdy0);
      checkOutput($sformatf("tbl%0d_s1_ready", k), s1_ready, 0);
      @(posedge HCLK); @(negedge HCLK);
      checkOutput($sformatf("tbl%0d_wr_en", k), wr_en, tbl[k].eEn);
      checkOutput($sformatf("tbl%0d_last", k), wr_last, tbl[k].eLast);
      checkOutput($sformatf("tbl%0d_done", k), frame_done, tbl[k].eDone);
      checkOutput($sformatf("tbl%0d_busy", k), busy, tbl[k].eBusy);
      if (tbl[k].eBusy) checkOutput($sformatf("tbl%0d_src", k), wr_src, 0);
      if (tbl[k].eEn) begin
        checkOutput($sformatf("tbl%0d_rc", k), {wr_row, wr_col}, {tbl[k].eRow, tbl[k].eCol});
        checkOutput($sformatf("tbl%0d_pix", k), {wr_r, wr_g, wr_b}, {tbl[k].pix, ~tbl[k].pix, tbl[k].pix ^ 8'h5A});
      end
    end

    // Both sources requesting for three frames: grants alternate, two-cycle gap.
    doReset();
    for (int c = 0; c < 30; c++) begin
      s0_valid = 1; s1_valid = 1; wr_ready = 1;
      randPix();
      modelCycle();
      if (wr_en) enIdx.push_back(c);
      if (frame_done) srcAtDone.push_back(int'(wr_src));
    end
    checkOutput("rr_pixel_count", enIdx.size(), 24);
    checkOutput("rr_frame_count", srcAtDone.size(), 3);
    if (srcAtDone.size() == 3)
      checkOutput("rr_grant_order", {srcAtDone[0][0], srcAtDone[1][0], srcAtDone[2][0]}, 3'b010);
    if (enIdx.size() == 24) begin
      checkOutput("rr_gap1", enIdx[8] - enIdx[7] - 1, 2);
      checkOutput("rr_gap2", enIdx[16] - enIdx[15] - 1, 2);
    end

    // Reset mid-frame, then the next frame restarts at (0,0).
    doReset();
    s0_valid = 1; s1_valid = 1;
    for (int c = 0; c < 5; c++) begin randPix(); modelCycle(); end
    #2 HRESETn = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_wr_en", wr_en, 0);
    @(negedge HCLK);
    HRESETn = 1'b1; s1_valid = 0;
    modelReset();
    seenFirst = 0;
    for (int c = 0; c < 12; c++) begin
      randPix();
      modelCycle();
      if (wr_en && !seenFirst) begin
        seenFirst = 1;
        checkOutput("midrst_first_rc", {wr_row, wr_col}, 0);
      end
    end
    checkOutput("midrst_restarted", seenFirst, 1);

    // wr_ready toggling every cycle from the first STREAM cycle.
    doReset();
    s0_valid = 1; s1_valid = 0; nStream = 0; nEn = 0;
    for (int c = 0; c < 20; c++) begin
      wr_ready = (c == 0) ? 1'b1 : (c % 2 == 0);
      if (c >= 17) s0_valid = 0;
      if (busy && !frame_done) nStream++;
      randPix();
      modelCycle();
      if (wr_en) nEn++;
    end
    checkOutput("toggle_pixels", nEn, 8);
    checkOutput("toggle_stream_cycles", nStream, 16);

    // Source stalls after three pixels.
    doReset();
    s0_valid = 1; s1_valid = 1; wr_ready = 1;
    lastXfer = -1; abortAt = -1; nDone = 0; nEn = 0;
    for (int c = 0; c < 130; c++) begin
      if (c == 4) s0_valid = 0;
      randPix();
      modelCycle();
      if (wr_en && c <= 10) begin nEn++; lastXfer = c; end
      if (frame_abort && abortAt < 0) abortAt = c;
      if (frame_done && c <= 11) nDone++;
`ifdef ARB_TIMEOUT_EN
      if (c == 12) begin
        checkOutput("abort_next_busy", busy, 1);
        checkOutput("abort_next_src", wr_src, 1);
      end
`endif
    end
    checkOutput("stall_pixels", nEn, 3);
    checkOutput("stall_no_done", nDone, 0);
`ifdef ARB_TIMEOUT_EN
    checkOutput("abort_delay", abortAt - lastXfer, 6);
`else
    checkOutput("no_abort", abortAt, -1);
    checkOutput("held_busy", busy, 1);
    checkOutput("held_src", wr_src, 0);
`endif

    // Randomized traffic against the reference model.
    doReset();
    for (int c = 0; c < 600; c++) begin
      s0_valid = ($urandom % 4) != 0;
      s1_valid = ($urandom % 4) != 0;
      wr_ready = ($urandom % 4) != 0;
      randPix();
      modelCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/bmp_frame_arbiter.md
# bmp_frame_arbiter

Frame-granular arbiter that shares the single BMP writer pixel port between two upstream image-processing pipelines. It sits between two filter outputs and the writer. It grants one source for a whole WIDTH×HEIGHT frame, forwards that source's pixels with row/column coordinates under writer back-pressure, and then pulses frame completion. Grant alternates round-robin between frames.

## Interface
- WIDTH, 768: pixels per row.
- HEIGHT, 512: rows per frame.
- TIMEOUT, 1024: stall limit in cycles; used only with the timeout feature (see Configuration).
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- s0_valid / s1_valid  in  1  source pixel valid.
- s0_r, s0_g, s0_b / s1_r, s1_g, s1_b  in  8 each  source RGB888 pixel.
- s0_ready / s1_ready  out  1  source accept; combinational.
- wr_ready  in  1  writer can accept a pixel this cycle.
- wr_en  out  1  registered pixel strobe to the writer.
- wr_r, wr_g, wr_b  out  8 each  registered pixel data.
- wr_row, wr_col  out  16 each  coordinates of the pixel on wr_en; row 0 is the top row.
- wr_last  out  1  marks the final pixel of the frame, coincident with wr_en.
- wr_src  out  1  index of the granted source; valid while busy.
- busy  out  1  high in STREAM and DONE.
- frame_done  out  1  one-cycle pulse on normal frame completion.
- frame_abort  out  1  one-cycle pulse on timeout abort; tied to 0 without the macro.

## Operation
- **States:**
  - IDLE:
    - If any sx_valid is high, latch the grant and go to STREAM.
    - If both are high, grant the source named by prio.
    - If exactly one is high, grant that source.
    - If none is high, stay in IDLE.
  - STREAM: forward pixels from the granted source. On the transfer where col==WIDTH-1 and row==HEIGHT-1, go to DONE.
  - DONE: lasts exactly one cycle. Set prio = ~wr_src, clear row/col, then go to IDLE.
- **Handshake:**
  - sx_ready = (state==STREAM) && (grant==x) && wr_ready.
  - A transfer occurs when sx_valid && sx_ready.
  - The non-granted source's ready stays 0 for the entire frame.
- **Output registering:** on each transfer, the next edge loads wr_r/g/b from the source and wr_row/wr_col from the counters, and sets wr_en=1. wr_en is 0 on every other cycle.
- **Counters:**
  - col increments on each transfer.
  - At col==WIDTH-1, col wraps to 0 and row increments.
  - Counters are 16-bit; WIDTH and HEIGHT must each be ≤ 65535.
  - Counters do not advance without a transfer.
- **Frame end:** frame_done=1 during the DONE cycle. wr_last=1 in the same cycle as the final wr_en.
- **Reset values (asynchronous on HRESETn low, at any time including mid-frame):**
  - State returns to IDLE.
  - prio=0, row=col=0, stall counter=0.
  - All outputs are 0: wr_en, wr_r/g/b, wr_row/wr_col, wr_last, wr_src, busy, frame_done, frame_abort.
  - A partial frame is discarded and is not resumed.

## Timing
- Latency: 1 cycle from a transfer edge to wr_en.
- The final transfer at edge t gives wr_en, wr_last and frame_done high at t+1 (DONE state).
  - State is IDLE at t+2.
  - The earliest next-frame transfer is at t+3.
- A source valid that is high during DONE is not granted until IDLE.
- With wr_ready stuck high and valid continuous, throughput is 1 pixel per cycle.
- A wr_ready drop takes effect the same cycle; no pixel is lost or duplicated.
- Toggling or dropping valid mid-frame holds the grant and the counters.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - In STREAM, a 16-bit counter increments on each cycle with wr_ready=1 and the granted valid=0. It clears on any transfer.
  - When the counter reaches TIMEOUT, go to DONE without completing the frame.
  - In DONE, frame_abort pulses instead of frame_done and wr_last is not asserted.
  - prio flips as normal.
  - Stall cycles caused by wr_ready=0 are not counted.
- **ARB_TIMEOUT_EN undefined:**
  - There is no counter.
  - A stalled source holds the grant indefinitely.
  - frame_abort is constant 0.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (8 pixels per frame), wr_ready=1 unless stated otherwise.
- Reset release with both valids low: all outputs 0, state IDLE. Assert HRESETn low mid-frame → busy=0 and wr_en=0 immediately; the next frame restarts at row 0, col 0.
- s0 alone streams 8 pixels, valid continuous:
  - wr_en is high for 8 cycles, starting 1 cycle after the first transfer.
  - Coordinates run (0,0),(0,1),(0,2),(0,3),(1,0)…(1,3).
  - wr_last and frame_done are high together with pixel (1,3).
  - s1_ready stays 0 throughout.
- Both valids held high for 3 frames → grants go s0, s1, s0, with wr_src matching; the gap between frames is 2 cycles.
- Toggle wr_ready 1/0 every cycle during a frame:
  - Each of the 8 pixels appears exactly once, in order.
  - The frame takes 16 cycles of streaming.
  - sx_ready follows wr_ready in the same cycle.
- ARB_TIMEOUT_EN with TIMEOUT=5: s0 sends 3 pixels, then drops valid.
  - frame_abort pulses 6 cycles after the last transfer; frame_done stays 0.
  - s1 is granted next.
  - Without the macro, the grant is held for 100+ cycles with no pulse.
